nes_oam_dma: RTL and testbench



---
 rtl/nes_pkg.sv | 45 ++++
 rtl/nes_oam_dma.sv | 97 +++++++++
 tb/tb_nes_oam_dma.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/nes_pkg.sv
// Shared NES register map and OAM DMA state encoding, reused by the PPU/APU glue.
package nes_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HALT,
    ST_ALIGN,
    ST_READ,
    ST_WRITE
  } dma_state_t;

  // PPU registers, mirrored every 8 bytes through $3FFF
  localparam logic [15:0] PPU_CTRL   = 16'h2000;
  localparam logic [15:0] PPU_MASK   = 16'h2001;
  localparam logic [15:0] PPU_STATUS = 16'h2002;
  localparam logic [15:0] OAM_ADDR   = 16'h2003;
  localparam logic [15:0] OAM_DATA   = 16'h2004;
  localparam logic [15:0] PPU_SCROLL = 16'h2005;
  localparam logic [15:0] PPU_ADDR   = 16'h2006;
  localparam logic [15:0] PPU_DATA   = 16'h2007;

  // APU and I/O registers
  localparam logic [15:0] APU_SQ1_VOL  = 16'h4000;
  localparam logic [15:0] APU_SQ2_VOL  = 16'h4004;
  localparam logic [15:0] APU_TRI_LIN  = 16'h4008;
  localparam logic [15:0] APU_NOISE    = 16'h400C;
  localparam logic [15:0] APU_DMC_FREQ = 16'h4010;
  localparam logic [15:0] APU_DMC_LEN  = 16'h4013;
  localparam logic [15:0] OAM_DMA      = 16'h4014;
  localparam logic [15:0] APU_STATUS   = 16'h4015;
  localparam logic [15:0] JOY1         = 16'h4016;
  localparam logic [15:0] JOY2_FRAME   = 16'h4017;

  localparam logic [15:0] DMA_REG = OAM_DMA;
  localparam logic [15:0] OAM_REG = OAM_DATA;

  function automatic logic is_ppu_reg(input logic [15:0] addr);
    return addr[15:13] == 3'b001;
  endfunction

  function automatic logic is_apu_io_reg(input logic [15:0] addr);
    return (addr >= APU_SQ1_VOL) && (addr <= JOY2_FRAME);
  endfunction

endpackage

// File: rtl/nes_oam_dma.sv
// OAM DMA engine and CPU/DMA bus arbiter: a $4014 write stalls the core and
// copies page $XX00-$XXFF into OAM_DATA with cycle-accurate 513/514 stall.
module nes_oam_dma #(
  parameter logic [15:0] DMA_REG = 16'h4014,
  parameter logic [15:0] OAM_REG = 16'h2004
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        ce,
  output logic        cpu_locked,
  input  logic [15:0] cpu_address,
  input  logic [7:0]  cpu_out,
  input  logic        cpu_we,
  input  logic        cpu_rd,
  output logic [7:0]  cpu_in,
  output logic [15:0] mem_address,
  output logic [7:0]  mem_out,
  input  logic [7:0]  mem_in,
  output logic        mem_we,
  output logic        mem_rd,
  output logic        busy
);
  import nes_pkg::*;

  dma_state_t state, state_nx;
  logic [7:0] page;
  logic [7:0] idx;
  logic [7:0] data;
  logic       odd;
  logic       trigger;

  assign trigger = cpu_we && (cpu_address == DMA_REG);

  // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (trigger) state_nx = ST_HALT;
      ST_HALT:  state_nx = odd ? ST_READ : ST_ALIGN;
      ST_ALIGN: state_nx = ST_READ;
      ST_READ:  state_nx = ST_WRITE;
      ST_WRITE: state_nx = (idx == 8'hFF) ? ST_IDLE : ST_READ;
      default:  state_nx = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
      page  <= '0;
      idx   <= '0;
      data  <= '0;
      odd   <= 1'b0;
    end else if (ce) begin
      state <= state_nx;
      odd   <= ~odd;
      if (state == ST_IDLE && trigger) begin
        page <= cpu_out;
        idx  <= '0;
      end
      if (state == ST_READ) data <= mem_in;
      // idx stops at $FF on the final write; it never carries into page
      if (state == ST_WRITE && idx != 8'hFF) idx <= idx + 8'd1;
    end
  end

  always_comb begin
    mem_address = cpu_address;
    mem_out     = cpu_out;
    mem_we      = cpu_we;
    mem_rd      = cpu_rd;
    case (state)
      ST_HALT, ST_ALIGN: begin
        mem_we = 1'b0;
        mem_rd = 1'b0;
      end
      ST_READ: begin
        mem_address = {page, idx};
        mem_we      = 1'b0;
        mem_rd      = 1'b1;
      end
      ST_WRITE: begin
        mem_address = OAM_REG;
        mem_out     = data;
        mem_we      = 1'b1;
        mem_rd      = 1'b0;
      end
      default: ;
    endcase
  end

  assign cpu_locked = ce && (state == ST_IDLE);
  assign busy       = (state != ST_IDLE);
  assign cpu_in     = mem_in;

endmodule

// File: tb/tb_nes_oam_dma.sv
// Self-checking bench for nes_oam_dma: table-driven CPU passthrough vectors plus
// directed DMA sequences (parity, page wrap, ce gaps, mid-transfer reset).
module tb_nes_oam_dma;
  import nes_pkg::*;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        ce;
  logic        cpu_locked;
  logic [15:0] cpu_address;
  logic [7:0]  cpu_out;
  logic        cpu_we;
  logic        cpu_rd;
  logic [7:0]  cpu_in;
  logic [15:0] mem_address;
  logic [7:0]  mem_out;
  logic [7:0]  mem_in;
  logic        mem_we;
  logic        mem_rd;
  logic        busy;

  nes_oam_dma dut (
    .clock(clock), .reset_n(reset_n), .ce(ce), .cpu_locked(cpu_locked),
    .cpu_address(cpu_address), .cpu_out(cpu_out), .cpu_we(cpu_we), .cpu_rd(cpu_rd),
    .cpu_in(cpu_in), .mem_address(mem_address), .mem_out(mem_out), .mem_in(mem_in),
    .mem_we(mem_we), .mem_rd(mem_rd), .busy(busy)
  );

  always #5 clock = ~clock;

  // Read-only bus model: sources never change, so expected bytes come straight from it
  logic [7:0] ram [0:65535];
  assign mem_in = ram[mem_address];

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Independent parity model: number of ce edges since reset
  int ce_count;
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) ce_count <= 0;
    else if (ce) ce_count <= ce_count + 1;
  end

  logic [7:0]  wr_log[$];
  logic [15:0] rd_log[$];
  int stall;
  int zero_reads;

  always @(negedge clock) begin
    if (reset_n && ce) begin
      if (!cpu_locked) stall++;
      if (busy && mem_we && mem_address == OAM_REG) wr_log.push_back(mem_out);
      if (busy && mem_rd) begin
        rd_log.push_back(mem_address);
        if (mem_address == 16'h0000) zero_reads++;
      end
    end
  end

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  dout;
    logic        we, rd, ce;
    logic [15:0] e_addr;
    logic [7:0]  e_out;
    logic        e_we, e_rd, e_locked;
    logic [7:0]  e_in;
    logic        e_busy;
  } vec_t;

  vec_t vecs[7];

  task automatic idle_cycles(input int n);
    cpu_we = 1'b0;
    cpu_rd = 1'b0;
    ce     = 1'b1;
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic run_dma(input logic [7:0] pg, input bit halt_odd, input bit gaps, input string tag);
    int budget;
    int hold_errs;
    int bad;
    logic [26:0] snap;
    // HALT parity is the inverse of the trigger cycle parity
    if (ce_count[0] == halt_odd) idle_cycles(1);
    wr_log.delete();
    rd_log.delete();
    stall = 0;
    zero_reads = 0;
    cpu_address = DMA_REG;
    cpu_out = pg;
    cpu_we = 1'b1;
    cpu_rd = 1'b0;
    ce = 1'b1;
    #1;
    check({tag, " trigger on bus"}, {busy, mem_we, mem_rd, mem_address, mem_out}, {3'b010, DMA_REG, pg});
    @(posedge clock);
    #1;
    check({tag, " halt bus idle"}, {busy, mem_we, mem_rd, mem_address}, {3'b100, DMA_REG});
    budget = 0;
    hold_errs = 0;
    // The core keeps its $4014 write asserted while frozen; it must be ignored
    while (busy && budget < 4000) begin
      ce = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      #1;
      snap = {busy, mem_address, mem_we, mem_rd, mem_out};
      @(posedge clock);
      #1;
      if (!ce && snap != {busy, mem_address, mem_we, mem_rd, mem_out}) hold_errs++;
      budget++;
    end
    cpu_we = 1'b0;
    ce = 1'b1;
    check({tag, " finished in budget"}, {busy, 31'(budget < 4000)}, {1'b0, 31'd1});
    check({tag, " stall cycles"}, stall, halt_odd ? 513 : 514);
    check({tag, " write count"}, wr_log.size(), 256);
    check({tag, " read count"}, rd_log.size(), 256);
    bad = 0;
    for (int i = 0; i < 256; i++) begin
      if (i < wr_log.size() && wr_log[i] !== ram[{pg, 8'(i)}]) bad++;
      if (i < rd_log.size() && rd_log[i] !== {pg, 8'(i)}) bad++;
    end
    check({tag, " data/address order"}, bad, 0);
    check({tag, " no $0000 access"}, zero_reads, (pg == 8'h00) ? 1 : 0);
    if (gaps) check({tag, " hold while ce=0"}, hold_errs, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int budget;
    for (int a = 0; a < 65536; a++) ram[a] = 8'((a * 13) ^ (a >> 8) ^ 8'h5A);
    ram[16'hFFFF] = 8'hAB;
    ram[16'h0000] = 8'h5A;
    ram[16'h2004] = 8'hC3;
    ram[16'h4013] = 8'h9E;
    ram[16'h4014] = 8'h00;
    ram[16'h4015] = 8'h1F;
    ram[16'h4016] = 8'h41;

    //          addr      dout   we    rd    ce    e_addr    e_out  e_we  e_rd  e_lock e_in   e_busy
    vecs[0] = '{16'h2004, 8'h77, 1'b1, 1'b0, 1'b1, 16'h2004, 8'h77, 1'b1, 1'b0, 1'b1, 8'hC3, 1'b0};
    vecs[1] = '{16'h4015, 8'h00, 1'b0, 1'b1, 1'b1, 16'h4015, 8'h00, 1'b0, 1'b1, 1'b1, 8'h1F, 1'b0};
    vecs[2] = '{16'h4013, 8'h55, 1'b1, 1'b0, 1'b1, 16'h4013, 8'h55, 1'b1, 1'b0, 1'b1, 8'h9E, 1'b0};
    vecs[3] = '{16'h4014, 8'h02, 1'b1, 1'b0, 1'b0, 16'h4014, 8'h02, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0};
    vecs[4] = '{16'h4014, 8'h02, 1'b0, 1'b1, 1'b1, 16'h4014, 8'h02, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0};
    vecs[5] = '{16'h4015, 8'h02, 1'b1, 1'b0, 1'b1, 16'h4015, 8'h02, 1'b1, 1'b0, 1'b1, 8'h1F, 1'b0};
    vecs[6] = '{16'h4016, 8'hAA, 1'b0, 1'b1, 1'b0, 16'h4016, 8'hAA, 1'b0, 1'b1, 1'b0, 8'h41, 1'b0};

    reset_n = 1'b0;
    ce = 1'b1;
    cpu_address = 16'h2002;
    cpu_out = 8'h00;
    cpu_we = 1'b0;
    cpu_rd = 1'b1;
    #12;
    check("reset busy", busy, 0);
    check("reset locked follows ce", cpu_locked, 1);
    check("reset bus follows cpu", {mem_we, mem_rd, mem_address}, {2'b01, 16'h2002});
    ce = 1'b0;
    #1;
    check("reset locked with ce=0", cpu_locked, 0);
    #4;
    reset_n = 1'b1;
    idle_cycles(2);

    foreach (vecs[i]) begin
      cpu_address = vecs[i].addr;
      cpu_out = vecs[i].dout;
      cpu_we = vecs[i].we;
      cpu_rd = vecs[i].rd;
      ce = vecs[i].ce;
      #1;
      check($sformatf("vec%0d address", i), mem_address, vecs[i].e_addr);
      check($sformatf("vec%0d wdata", i), mem_out, vecs[i].e_out);
      check($sformatf("vec%0d we/rd", i), {mem_we, mem_rd}, {vecs[i].e_we, vecs[i].e_rd});
      check($sformatf("vec%0d locked", i), cpu_locked, vecs[i].e_locked);
      check($sformatf("vec%0d cpu_in", i), cpu_in, vecs[i].e_in);
      @(posedge clock);
      #1;
      check($sformatf("vec%0d busy", i), busy, vecs[i].e_busy);
    end
    idle_cycles(1);

    run_dma(8'h02, 1'b1, 1'b0, "odd");
    run_dma(8'h02, 1'b0, 1'b0, "even");
    run_dma(8'hFF, 1'b1, 1'b0, "pageff");
    check("pageff last write", (wr_log.size() == 256) ? wr_log[255] : 8'h00, 8'hAB);
    idle_cycles(1);
    check("pageff back to idle", {busy, cpu_locked}, 2'b01);
    run_dma(8'h05, 1'b0, 1'b1, "gaps");

    // Reset asserted while the READ of idx=$40 is on the bus
    idle_cycles(1);
    cpu_address = DMA_REG;
    cpu_out = 8'h03;
    cpu_we = 1'b1;
    ce = 1'b1;
    @(posedge clock);
    #1;
    budget = 0;
    while (!(mem_rd && mem_address == 16'h0340) && budget < 2000) begin
      @(posedge clock);
      #1;
      budget++;
    end
    check("midreset reached idx 40", {busy, 31'(budget < 2000)}, {1'b1, 31'd1});
    cpu_address = 16'h1234;
    cpu_we = 1'b0;
    cpu_rd = 1'b0;
    #1;
    reset_n = 1'b0;
    #1;
    check("midreset busy async", busy, 0);
    check("midreset bus to cpu", {mem_we, mem_rd, mem_address}, {2'b00, 16'h1234});
    check("midreset locked", cpu_locked, 1);
    @(posedge clock);
    #3;
    reset_n = 1'b1;
    idle_cycles(2);
    check("after reset still idle", busy, 0);
    run_dma(8'h04, 1'b1, 1'b0, "restart");
    check("restart first read", (rd_log.size() > 0) ? rd_log[0] : 16'hDEAD, 16'h0400);
    idle_cycles(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
